// File: rtl/mem_channel_arbiter_pkg.sv
// Shared types and default widths for the memory channel arbiter.
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 256;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

  // Width of a counter that must reach t; never narrower than 1 bit.
  function automatic int cnt_w(input int t);
    int w;
    w = $clog2(t + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_channel_arbiter_if.sv
// Bundle of the N-channel master side and the single slave side.
// modport master is the arbiter's view; modport slave is the environment
// (compute engines plus memory) driving requests and slave responses.
interface mem_channel_arbiter_if
  import mem_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  localparam int GW = $clog2(N_CH);

  logic [N_CH-1:0]        m_req;
  logic [N_CH-1:0]        m_w_en;
  logic [N_CH*ADDR_W-1:0] m_addr;
  logic [N_CH*DATA_W-1:0] m_wdata;
  logic [N_CH-1:0]        m_ack;
  logic [N_CH-1:0]        m_err;
  logic [DATA_W-1:0]      m_rdata;
  logic                   s_req;
  logic                   s_w_en;
  logic [ADDR_W-1:0]      s_addr;
  logic [DATA_W-1:0]      s_wdata;
  logic                   s_ack;
  logic [DATA_W-1:0]      s_rdata;
  logic                   busy;
  logic [GW-1:0]          grant_id;

  modport master (
    input  m_req, m_w_en, m_addr, m_wdata, s_ack, s_rdata,
    output m_ack, m_err, m_rdata, s_req, s_w_en, s_addr, s_wdata, busy, grant_id
  );

  modport slave (
    output m_req, m_w_en, m_addr, m_wdata, s_ack, s_rdata,
    input  m_ack, m_err, m_rdata, s_req, s_w_en, s_addr, s_wdata, busy, grant_id
  );

endinterface

// File: rtl/mem_rr_pick.sv
// Round-robin picker: rotate requests so ptr is at bit 0, take the lowest
// set bit, and map the index back into channel numbering.
module mem_rr_pick #(
  parameter  int N_CH = 4,
  localparam int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [N_CH-1:0] rot;
  int              idx;
  int              j;

  // rotate, find-first, rotate back
  always_comb begin
    rot = '0;
    idx = 0;
    j   = 0;
    for (int i = 0; i < N_CH; i++) begin
      j = i + int'(ptr);
      if (j >= N_CH) j = j - N_CH;
      rot[i] = req[j];
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) idx = i;
    end
    j = idx + int'(ptr);
    if (j >= N_CH) j = j - N_CH;
    winner = IW'(j);
    valid  = |req;
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// N-channel round-robin arbiter onto one registered memory slave port,
// with an optional slave timeout that returns an error response.
module mem_channel_arbiter
  import mem_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_channel_arbiter_if.master bus
);

  localparam int GW      = $clog2(N_CH);
  localparam int CNT_W   = cnt_w(TIMEOUT_CYC);
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  arb_state_t        state, nxt;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     grant;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              s_req_q;
  logic              s_w_en_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic [GW-1:0]     win;
  logic              win_vld;
  logic              timeout;
  logic [N_CH-1:0]   gsel;

  mem_rr_pick #(.N_CH(N_CH)) u_pick (
    .req    (bus.m_req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_vld)
  );

  // counter value in the last ISSUE cycle before giving up
  assign timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // next-state: s_ack takes priority over a simultaneous timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (win_vld) nxt = ISSUE;
      ISSUE:   if (bus.s_ack || timeout) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // grant latch, slave request registers, response capture, rr pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      s_req_q   <= 1'b0;
      s_w_en_q  <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      s_req_q <= (nxt == ISSUE);
      case (state)
        IDLE: if (win_vld) begin
          grant     <= win;
          s_w_en_q  <= bus.m_w_en[win];
          s_addr_q  <= bus.m_addr[int'(win)*ADDR_W +: ADDR_W];
          s_wdata_q <= bus.m_wdata[int'(win)*DATA_W +: DATA_W];
          cnt       <= '0;
          err       <= 1'b0;
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (bus.s_ack) begin
            rdata <= bus.s_rdata;
            err   <= 1'b0;
          end else if (timeout) begin
            rdata <= '0;
            err   <= 1'b1;
          end
        end
        RESP: ptr <= (grant == GW'(N_CH - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

  // one-hot select of the granted channel for the response pulse
  always_comb begin
    gsel        = '0;
    gsel[grant] = 1'b1;
  end

  assign bus.s_req    = s_req_q;
  assign bus.s_w_en   = s_w_en_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m_ack    = (state == RESP) ? gsel : '0;
  assign bus.m_err    = (state == RESP && err) ? gsel : '0;
  assign bus.m_rdata  = rdata;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Randomized bench: a transaction-level model tracks pending master
// requests, the round-robin pointer and per-transaction slave latency,
// and predicts every output cycle by cycle.
module tb_mem_channel_arbiter;
  import mem_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int TO = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_channel_arbiter_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_channel_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int n_vec, n_bad;

  // model state
  logic [N-1:0]  pend;
  logic [N-1:0]  wen_m;
  logic [AW-1:0] addr_m [N];
  logic [DW-1:0] wd_m   [N];
  int            ptr_m;
  int            last_gid;
  logic [DW-1:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic new_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[c]   = 1'b1;
    wen_m[c]  = w;
    addr_m[c] = a;
    wd_m[c]   = d;
  endtask

  task automatic rand_req(input int c);
    new_req(c, 1'($urandom_range(0, 1)), AW'($urandom), rnd());
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      bus.m_req[c]            = pend[c];
      bus.m_w_en[c]           = wen_m[c];
      bus.m_addr[c*AW +: AW]  = addr_m[c];
      bus.m_wdata[c*DW +: DW] = wd_m[c];
    end
  endtask

  task automatic idle_chk();
    chk("idle_busy",  64'(bus.busy), 64'd0);
    chk("idle_s_req", 64'(bus.s_req), 64'd0);
    chk("idle_m_ack", 64'(bus.m_ack), 64'd0);
    chk("idle_m_err", 64'(bus.m_err), 64'd0);
    chk("idle_grant", 64'(bus.grant_id), 64'(last_gid));
    chk("idle_rdata", 64'(bus.m_rdata), 64'(last_rd));
  endtask

  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
    idle_chk();
  endtask

  // One transaction, entered and left at a negedge of an IDLE cycle.
  // lat = ISSUE cycle in which the slave acks; lat > TO means never.
  task automatic xact(input int lat, input logic [DW-1:0] rd, input bit late, input bit rereq);
    int            win;
    int            n_iss;
    bit            tmo;
    logic [N-1:0]  oh;
    logic [DW-1:0] exp_rd;
    win = -1;
    for (int i = 0; i < N; i++) begin
      if (win < 0 && pend[(ptr_m + i) % N]) win = (ptr_m + i) % N;
    end
    oh      = '0;
    oh[win] = 1'b1;
    tmo     = (lat > TO);
    n_iss   = tmo ? TO : lat;
    exp_rd  = tmo ? '0 : rd;
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= n_iss; c++) begin
      chk("iss_s_req",  64'(bus.s_req), 64'd1);
      chk("iss_busy",   64'(bus.busy), 64'd1);
      chk("iss_m_ack",  64'(bus.m_ack), 64'd0);
      chk("iss_grant",  64'(bus.grant_id), 64'(win));
      chk("iss_s_w_en", 64'(bus.s_w_en), 64'(wen_m[win]));
      chk("iss_s_addr", 64'(bus.s_addr), 64'(addr_m[win]));
      chk("iss_s_wdata", 64'(bus.s_wdata), 64'(wd_m[win]));
      if (c == lat) begin
        bus.s_ack   = 1'b1;
        bus.s_rdata = rd;
      end
      @(posedge clk); @(negedge clk);
      bus.s_ack   = 1'b0;
      bus.s_rdata = rnd();
    end
    chk("resp_s_req", 64'(bus.s_req), 64'd0);
    chk("resp_busy",  64'(bus.busy), 64'd1);
    chk("resp_m_ack", 64'(bus.m_ack), 64'(oh));
    chk("resp_m_err", 64'(bus.m_err), tmo ? 64'(oh) : 64'd0);
    chk("resp_rdata", 64'(bus.m_rdata), 64'(exp_rd));
    if (late && tmo) begin
      bus.s_ack   = 1'b1;
      bus.s_rdata = rnd();
    end
    pend[win] = 1'b0;
    if (rereq) rand_req(win);
    drive();
    ptr_m    = (win + 1) % N;
    last_gid = win;
    last_rd  = exp_rd;
    @(posedge clk); @(negedge clk);
    bus.s_ack = 1'b0;
    idle_chk();
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    pend = '0; wen_m = '0; ptr_m = 0; last_gid = 0; last_rd = '0;
    for (int c = 0; c < N; c++) begin
      addr_m[c] = '0;
      wd_m[c]   = '0;
    end
    reset_n     = 1'b0;
    bus.s_ack   = 1'b0;
    bus.s_rdata = '0;
    drive();
    repeat (2) @(negedge clk);
    chk("rst_s_req",  64'(bus.s_req), 64'd0);
    chk("rst_s_w_en", 64'(bus.s_w_en), 64'd0);
    chk("rst_s_addr", 64'(bus.s_addr), 64'd0);
    chk("rst_s_wdata", 64'(bus.s_wdata), 64'd0);
    chk("rst_m_ack",  64'(bus.m_ack), 64'd0);
    chk("rst_m_err",  64'(bus.m_err), 64'd0);
    chk("rst_rdata",  64'(bus.m_rdata), 64'd0);
    chk("rst_busy",   64'(bus.busy), 64'd0);
    chk("rst_grant",  64'(bus.grant_id), 64'd0);
    reset_n = 1'b1;
    idle_cycle();

    // every channel keeps requesting, zero-wait slave
    for (int c = 0; c < N; c++) rand_req(c);
    drive();
    for (int i = 0; i < 6; i++) begin
      xact(1, rnd(), 1'b0, 1'b1);
      chk("rr_order", 64'(bus.grant_id), 64'(i % N));
    end
    pend = '0;
    drive();

    // single read on ch2
    new_req(2, 1'b0, 16'h0040, {8{8'hA5}});
    drive();
    xact(1, {8{8'hA5}}, 1'b0, 1'b0);
    chk("read_rdata", 64'(bus.m_rdata), {8{8'hA5}});

    // write on ch1
    new_req(1, 1'b1, 16'h1234, 64'hDEAD_BEEF);
    drive();
    xact(2, rnd(), 1'b0, 1'b0);

    // slave never acks, then a stray ack after the timeout
    rand_req(3);
    drive();
    xact(TO + 2, rnd(), 1'b1, 1'b0);
    idle_cycle();

    // ack in the same cycle the timeout would fire
    rand_req(0);
    drive();
    xact(TO, rnd(), 1'b0, 1'b0);

    // random traffic
    repeat (150) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c] && $urandom_range(0, 2) == 0) rand_req(c);
      end
      drive();
      if (pend == '0) idle_cycle();
      else xact($urandom_range(1, TO + 2), rnd(), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0);
    end

    // reset while the slave request is outstanding
    for (int c = 0; c < N; c++) rand_req(c);
    drive();
    @(posedge clk); @(negedge clk);
    chk("pre_rst_s_req", 64'(bus.s_req), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_s_req", 64'(bus.s_req), 64'd0);
    chk("arst_busy",  64'(bus.busy), 64'd0);
    chk("arst_m_ack", 64'(bus.m_ack), 64'd0);
    chk("arst_grant", 64'(bus.grant_id), 64'd0);
    chk("arst_rdata", 64'(bus.m_rdata), 64'd0);
    chk("arst_s_addr", 64'(bus.s_addr), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("arst_m_ack2", 64'(bus.m_ack), 64'd0);
    reset_n  = 1'b1;
    ptr_m    = 0;
    last_gid = 0;
    last_rd  = '0;
    xact(1, rnd(), 1'b0, 1'b0);
    chk("post_rst_grant", 64'(bus.grant_id), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
